perceptron_pred_core: RTL

Parametrised perceptron branch predictor core with decoupled predict and resolve handshakes, bipolar global history, saturating weights and hardware weight clear on reset. It sits behind the Tiny Tapeout pin wrapper, which maps pins onto its valid/ready ports, and replaces the fixed-size predictor datapath. Weights live in an internal flop-array sub-module with one row per perceptron. One branch is outstanding at a time.

---
 rtl/perceptron_pkg.sv | 33 +++
 rtl/perceptron_weight_ram.sv | 36 +++
 rtl/perceptron_pred_core.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared state type, index hash and saturating weight step
package perceptron_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_COMPUTE,
        ST_WAIT_RES,
        ST_TRAIN
    } state_t;

    // Bounds for the widest supported weight; narrower weights scale these down.
    localparam int MAX_WEIGHT_W = 16;
    localparam int WMAX         = 2 ** (MAX_WEIGHT_W - 1) - 1;
    localparam int WMIN         = -WMAX;

    function automatic logic [31:0] hash_idx(input logic [31:0] addr, input int idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return ((addr >> 2) ^ (addr >> (2 + idx_w))) & mask;
    endfunction

    function automatic logic signed [15:0] sat_add(input logic signed [15:0] w,
                                                   input logic              up,
                                                   input logic signed [15:0] hi,
                                                   input logic signed [15:0] lo);
        if (up) begin
            return (w >= hi) ? hi : w + 16'sd1;
        end
        return (w <= lo) ? lo : w - 16'sd1;
    endfunction

endpackage

// File: rtl/perceptron_weight_ram.sv
// rtl/perceptron_weight_ram.sv - flop-array weight table with async read, one write port and row clear
module perceptron_weight_ram #(
    parameter int ROWS     = 16,
    parameter int COLS     = 8,
    parameter int WEIGHT_W = 8,
    parameter int ROW_W    = 4,
    parameter int COL_W    = 3
) (
    input  logic                       clk,
    input  logic [ROW_W-1:0]           rd_row,
    input  logic [COL_W-1:0]           rd_col,
    output logic signed [WEIGHT_W-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [ROW_W-1:0]           wr_row,
    input  logic [COL_W-1:0]           wr_col,
    input  logic signed [WEIGHT_W-1:0] wr_data,
    input  logic                       clr,
    input  logic [ROW_W-1:0]           clr_row
);

    logic signed [WEIGHT_W-1:0] mem [ROWS][COLS];

    assign rd_data = mem[rd_row][rd_col];

    // No reset here: the core's INIT sweep clears every row after reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < COLS; c++) begin
                mem[clr_row][COL_W'(c)] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

endmodule

// File: rtl/perceptron_pred_core.sv
// rtl/perceptron_pred_core.sv - perceptron branch predictor with predict/resolve handshakes
module perceptron_pred_core
    import perceptron_pkg::*;
#(
    parameter int ADDR_W          = 8,
    parameter int HIST_LEN        = 7,
    parameter int WEIGHT_W        = 8,
    parameter int NUM_PERCEPTRONS = 16,
    parameter int THRESHOLD       = 15,
    parameter int SUM_W           = WEIGHT_W + $clog2(HIST_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pred_req_valid,
    output logic                    pred_req_ready,
    input  logic [ADDR_W-1:0]       pred_req_addr,
    output logic                    pred_valid,
    output logic                    pred_taken,
    output logic signed [SUM_W-1:0] pred_sum,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic                    res_taken,
    output logic                    init_done,
    output logic                    mispredict,
    output logic                    trained,
    output logic [HIST_LEN-1:0]     hist
);

    localparam int IDX_W   = $clog2(NUM_PERCEPTRONS);
    localparam int COL_W   = $clog2(HIST_LEN + 1);
    localparam int W_SHIFT = MAX_WEIGHT_W - WEIGHT_W;
    localparam logic signed [15:0] W_HI = 16'(WMAX >> W_SHIFT);
    localparam logic signed [15:0] W_LO = 16'(-((-WMIN) >> W_SHIFT));
    localparam logic [COL_W-1:0]   LAST_COL = COL_W'(HIST_LEN);
    localparam logic [IDX_W-1:0]   LAST_ROW = IDX_W'(NUM_PERCEPTRONS - 1);

    state_t                     state, state_nx;
    logic [IDX_W-1:0]           init_row, idx;
    logic [COL_W-1:0]           col;
    logic signed [SUM_W-1:0]    acc, sum_nx;
    logic                       res_t;
    logic signed [WEIGHT_W-1:0] rd_data, wr_data;
    logic signed [15:0]         rd_ext;
    logic signed [31:0]         sum_ext;
    logic [HIST_LEN:0]          x_vec;
    logic                       x_pos, need_train, hist_in, wr_en, clr;
    logic [HIST_LEN-1:0]        hist_nx;

    // Bipolar input for the current column: bit 0 is the constant bias input.
    assign x_vec  = {hist, 1'b1};
    assign x_pos  = x_vec[col];
    assign sum_nx = x_pos ? acc + SUM_W'(rd_data) : acc - SUM_W'(rd_data);
    assign rd_ext = 16'(rd_data);
    assign wr_data = WEIGHT_W'(sat_add(rd_ext, x_pos == res_t, W_HI, W_LO));

    assign sum_ext    = 32'(pred_sum);
    assign need_train = (res_taken != pred_taken) ||
                        (sum_ext <= THRESHOLD && sum_ext >= -THRESHOLD);
    assign hist_in    = (state == ST_TRAIN) ? res_t : res_taken;
    assign hist_nx    = HIST_LEN'({hist, hist_in});

    assign pred_req_ready = (state == ST_IDLE);
    assign res_ready      = (state == ST_WAIT_RES);

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        clr      = 1'b0;
        case (state)
            ST_INIT: begin
                clr = 1'b1;
                if (init_row == LAST_ROW) state_nx = ST_IDLE;
            end
            ST_IDLE:     if (pred_req_valid) state_nx = ST_COMPUTE;
            ST_COMPUTE:  if (col == LAST_COL) state_nx = ST_WAIT_RES;
            ST_WAIT_RES: if (res_valid) state_nx = need_train ? ST_TRAIN : ST_IDLE;
            ST_TRAIN: begin
                wr_en = !rst;
                if (col == LAST_COL) state_nx = ST_IDLE;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            init_row   <= '0;
            idx        <= '0;
            col        <= '0;
            acc        <= '0;
            res_t      <= 1'b0;
            init_done  <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_sum   <= '0;
            mispredict <= 1'b0;
            trained    <= 1'b0;
            hist       <= '0;
        end else begin
            state      <= state_nx;
            mispredict <= 1'b0;
            trained    <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_row <= init_row + 1'b1;
                    if (init_row == LAST_ROW) init_done <= 1'b1;
                end
                ST_IDLE: if (pred_req_valid) begin
                    idx <= IDX_W'(hash_idx(32'(pred_req_addr), IDX_W));
                    col <= '0;
                    acc <= '0;
                end
                ST_COMPUTE: begin
                    if (col == LAST_COL) begin
                        pred_valid <= 1'b1;
                        pred_taken <= ~sum_nx[SUM_W-1];
                        pred_sum   <= sum_nx;
                    end else begin
                        acc <= sum_nx;
                        col <= col + 1'b1;
                    end
                end
                ST_WAIT_RES: if (res_valid) begin
                    pred_valid <= 1'b0;
                    pred_taken <= 1'b0;
                    pred_sum   <= '0;
                    mispredict <= (res_taken != pred_taken);
                    res_t      <= res_taken;
                    col        <= '0;
                    if (!need_train) hist <= hist_nx;
                end
                ST_TRAIN: begin
                    if (col == LAST_COL) begin
                        trained <= 1'b1;
                        hist    <= hist_nx;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    perceptron_weight_ram #(
        .ROWS     (NUM_PERCEPTRONS),
        .COLS     (HIST_LEN + 1),
        .WEIGHT_W (WEIGHT_W),
        .ROW_W    (IDX_W),
        .COL_W    (COL_W)
    ) u_weights (
        .clk     (clk),
        .rd_row  (idx),
        .rd_col  (col),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_row  (idx),
        .wr_col  (col),
        .wr_data (wr_data),
        .clr     (clr),
        .clr_row (init_row)
    );

endmodule
